// File: rtl/instr_fetch_pkg.sv
// Shared types and opcode decode for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch1,
    StFetch2,
    StHold
  } state_e;

  localparam logic [3:0] OpRd  = 4'b0101;
  localparam logic [3:0] OpWr  = 4'b0110;
  localparam logic [3:0] OpBr  = 4'b0111;
  localparam logic [3:0] OpBrz = 4'b1000;

  // Opcodes that carry an operand in the following memory word.
  function automatic logic is_two_word(input logic [3:0] opcode);
    return opcode inside {OpRd, OpWr, OpBr, OpBrz};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of PC, instruction-memory, decoder and branch signals around the fetch unit.
interface instr_fetch_if #(
  parameter int unsigned word_size = 8
) ();

  logic [word_size-1:0] pc_count;
  logic                 inc_pc;
  logic                 load_pc;
  logic [word_size-1:0] pc_data;
  logic                 mem_req;
  logic [word_size-1:0] mem_addr;
  logic                 mem_ack;
  logic [word_size-1:0] mem_rdata;
  logic [word_size-1:0] ir;
  logic [word_size-1:0] operand;
  logic                 ir_valid;
  logic                 ir_ready;
  logic                 redirect;
  logic [word_size-1:0] redirect_addr;

  modport master (
    input  pc_count, mem_ack, mem_rdata, ir_ready, redirect, redirect_addr,
    output inc_pc, load_pc, pc_data, mem_req, mem_addr, ir, operand, ir_valid
  );

  modport slave (
    output pc_count, mem_ack, mem_rdata, ir_ready, redirect, redirect_addr,
    input  inc_pc, load_pc, pc_data, mem_req, mem_addr, ir, operand, ir_valid
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: reads one- or two-word instructions from memory and
// holds them for the decoder; a branch redirect reloads the PC and restarts fetch.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned word_size = 8
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_if.master    bus
);

  state_e               state_q;
  logic [word_size-1:0] ir_q;
  logic [word_size-1:0] operand_q;
  logic                 ir_valid_q;

  logic active;
  logic fetching;
  logic mem_req;
  logic ack_fire;
  logic load_pc;

  assign active   = (state_q != StIdle);
  assign fetching = (state_q == StFetch1) || (state_q == StFetch2);
  // Redirect suppresses the request so a same-cycle ack can never be captured.
  assign mem_req  = fetching && !bus.redirect;
  assign ack_fire = mem_req && bus.mem_ack;
  assign load_pc  = active && bus.redirect;

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_req ? bus.pc_count : '0;
  assign bus.inc_pc   = ack_fire;
  assign bus.load_pc  = load_pc;
  assign bus.pc_data  = load_pc ? bus.redirect_addr : '0;
  assign bus.ir       = ir_q;
  assign bus.operand  = operand_q;
  assign bus.ir_valid = ir_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      operand_q  <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch1;
        end
        StFetch1: begin
          if (bus.redirect) begin
            state_q <= StFetch1;
          end else if (ack_fire) begin
            ir_q <= bus.mem_rdata;
            if (is_two_word(bus.mem_rdata[word_size-1 -: 4])) begin
              state_q <= StFetch2;
            end else begin
              state_q    <= StHold;
              ir_valid_q <= 1'b1;
            end
          end
        end
        StFetch2: begin
          if (bus.redirect) begin
            state_q <= StFetch1;
          end else if (ack_fire) begin
            operand_q  <= bus.mem_rdata;
            state_q    <= StHold;
            ir_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (bus.redirect || bus.ir_ready) begin
            state_q    <= StFetch1;
            ir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have one parameter: word_size, default 8, the width of addresses and instruction words.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 pc_count  in  word_size  current program counter value.
REQ-006 inc_pc  out  1  increment request to the program counter.
REQ-007 load_pc  out  1  load request to the program counter.
REQ-008 pc_data  out  word_size  load value for the program counter.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  word_size  read address.
REQ-011 mem_ack  in  1  read data valid; sampled only while mem_req=1.
REQ-012 mem_rdata  in  word_size  read data.
REQ-013 ir  out  word_size  instruction register: opcode in bits [word_size-1:word_size-4].
REQ-014 operand  out  word_size  second instruction word.
REQ-015 ir_valid  out  1  ir and operand hold a complete instruction.
REQ-016 ir_ready  in  1  decoder accepts the instruction.
REQ-017 redirect  in  1  branch taken; restart fetch at redirect_addr.
REQ-018 redirect_addr  in  word_size  branch target.

Function
REQ-019 SHALL implement states IDLE, FETCH1, FETCH2 and HOLD.
REQ-020 IDLE SHALL move to FETCH1 on the first clock edge after rst is released.
REQ-021 In FETCH1/FETCH2 with redirect=0: mem_req=1 and mem_addr=pc_count, held stable until mem_ack=1.
REQ-022 inc_pc SHALL equal mem_req AND mem_ack, combinationally, so that the PC increments on the same edge that captures the data.
REQ-023 In FETCH1, on mem_ack=1: ir <= mem_rdata; next state is FETCH2 if the opcode is two-word, otherwise HOLD.
REQ-024 Two-word opcodes SHALL be 4'b0101 (RD), 4'b0110 (WR), 4'b0111 (BR) and 4'b1000 (BRZ).
REQ-025 In FETCH2, on mem_ack=1: operand <= mem_rdata; next state is HOLD.
REQ-026 Single-word instructions SHALL leave operand unchanged.
REQ-027 ir_valid SHALL be 1 only in HOLD; mem_req and inc_pc SHALL be 0 in HOLD and IDLE.
REQ-028 In HOLD, ir_ready=1 SHALL complete the transfer on that edge and move to FETCH1; ir_ready=0 SHALL hold ir, operand and ir_valid stable.
REQ-029 Latency: single-word instruction ir_valid one cycle after the ack cycle; two-word instruction one cycle after the second ack.
REQ-030 redirect=1 in any non-IDLE state SHALL:
  - drive load_pc=1 and pc_data=redirect_addr combinationally;
  - force mem_req=0 and inc_pc=0;
  - discard any mem_rdata in that cycle;
  - clear ir_valid;
  - move to FETCH1.
REQ-031 redirect SHALL win over a simultaneous mem_ack and a simultaneous ir_ready; a HOLD instruction is not transferred.
REQ-032 load_pc=0 whenever redirect=0; pc_data=0 when load_pc=0.
REQ-033 mem_ack while mem_req=0 SHALL be ignored.
REQ-034 Address wrap-around is the program counter's responsibility; this block passes pc_count unmodified.

Reset
REQ-035 rst=1 SHALL immediately force state=IDLE, ir=0, operand=0, ir_valid=0, mem_req=0, inc_pc=0, load_pc=0, pc_data=0.
REQ-036 Reset mid-fetch SHALL abandon the access; an ack arriving during or after reset SHALL NOT be captured.

Structure
REQ-037 Package instr_fetch_pkg SHALL hold the state enumeration, the opcode constants, and the two-word opcode decode function.
REQ-038 No sub-module is required; the FSM and its registers SHALL reside in instr_fetch.

Verification
REQ-039 Reset release, pc_count=0x00, mem_rdata=0x12, ack on second request cycle -> one inc_pc pulse on the ack cycle; ir=0x12; ir_valid next cycle; operand=0x00.
REQ-040 Fetch 0x70 then 0x3C -> two inc_pc pulses; ir=0x70; operand=0x3C; ir_valid one cycle after the second ack.
REQ-041 HOLD with ir_ready=0 for 5 cycles -> ir_valid=1 and ir stable throughout; mem_req=0; no inc_pc.
REQ-042 redirect=1, redirect_addr=0x40, in FETCH2 with mem_ack=1 -> load_pc=1; pc_data=0x40; inc_pc=0; operand unchanged; next FETCH1 with mem_addr following pc_count=0x40.
REQ-043 rst=1 in FETCH1 with mem_ack=1 -> all outputs zero immediately; ir=0; state IDLE; FETCH1 one cycle after release.
